// File: rtl/wb_cache_pkg.sv
// wb_cache_pkg: shared FSM state encoding, access-direction constants and default widths
// for the write-back cache controller.
package wb_cache_pkg;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_IDX_W  = 4;
  localparam logic RD = 1'b1;
  localparam logic WR = 1'b0;
  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WRITEBACK, S_FILL, S_DONE} state_t;
endpackage

// File: rtl/wb_cache_array.sv
// wb_cache_array: direct-mapped tag/data/valid/dirty storage with combinational read,
// one write port, and valid/dirty cleared by reset (tags and data are not).
module wb_cache_array import wb_cache_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IDX_W  = DEF_IDX_W,
  parameter int TAG_W  = DEF_ADDR_W - DEF_IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic              i_we,
  input  logic [TAG_W-1:0]  i_tag,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_dirty,
  output logic              o_valid,
  output logic              o_dirty,
  output logic [TAG_W-1:0]  o_tag,
  output logic [DATA_W-1:0] o_data
);
  localparam int LINES = 2 ** IDX_W;
  logic [LINES-1:0]  r_valid;
  logic [LINES-1:0]  r_dirty;
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [DATA_W-1:0] r_data [LINES];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_we) begin
      r_valid[i_idx] <= 1'b1;
      r_dirty[i_idx] <= i_dirty;
    end
  end
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_tag[i_idx]  <= i_tag;
      r_data[i_idx] <= i_data;
    end
  end
  assign o_valid = r_valid[i_idx];
  assign o_dirty = r_dirty[i_idx];
  assign o_tag   = r_tag[i_idx];
  assign o_data  = r_data[i_idx];
endmodule

// File: rtl/wb_cache_ctrl.sv
// wb_cache_ctrl: direct-mapped write-back cache responder (one word per line) between the
// load/store arbiter and memory. Optional hit/miss/write-back counters under WBC_STATS_EN.
module wb_cache_ctrl import wb_cache_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int IDX_W  = DEF_IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              rd_wrt_ca,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              idle,
  output logic              done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef WBC_STATS_EN
  ,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt,
  output logic [15:0]       wb_cnt
`endif
);
  localparam int TAG_W = ADDR_W - IDX_W;
  state_t r_state, w_next;
  logic r_rw, r_mem_req, r_mem_we;
  logic [ADDR_W-1:0] r_addr, r_mem_addr;
  logic [DATA_W-1:0] r_wdata, r_rd_data, r_mem_wdata;
  logic w_valid, w_dirty, w_hit, w_victim, w_lookup, w_ack, w_arr_we;
  logic [TAG_W-1:0] w_tag;
  logic [DATA_W-1:0] w_line;
  wb_cache_array #(.DATA_W(DATA_W), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_array (
    .clk(clk), .rst(rst), .i_idx(r_addr[IDX_W-1:0]), .i_we(w_arr_we),
    .i_tag(r_addr[ADDR_W-1:IDX_W]),
    .i_data((r_state == S_FILL && r_rw == RD) ? mem_rdata : r_wdata),
    .i_dirty(r_rw == WR), .o_valid(w_valid), .o_dirty(w_dirty), .o_tag(w_tag), .o_data(w_line)
  );
  assign w_lookup = r_state == S_LOOKUP;
  assign w_hit    = w_valid && w_tag == r_addr[ADDR_W-1:IDX_W];
  assign w_victim = w_valid && w_dirty;
  // An ack only counts against a request that is actually outstanding.
  assign w_ack    = r_mem_req && mem_ack;
  assign w_arr_we = (w_lookup && w_hit && r_rw == WR) || (r_state == S_FILL && w_ack);
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      w_next = enable ? S_LOOKUP : S_IDLE;
      S_LOOKUP:    w_next = w_hit ? S_DONE : (w_victim ? S_WRITEBACK : S_FILL);
      S_WRITEBACK: w_next = w_ack ? S_FILL : S_WRITEBACK;
      S_FILL:      w_next = w_ack ? S_DONE : S_FILL;
      default:     w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) r_state <= rst ? S_IDLE : w_next;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rw        <= RD;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rd_data   <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      if (r_state == S_IDLE && enable) begin
        r_rw    <= rd_wrt_ca;
        r_addr  <= addr;
        r_wdata <= wr_data;
      end
      if (w_lookup && w_hit && r_rw == RD) r_rd_data <= w_line;
      if (w_lookup && !w_hit) begin
        r_mem_req  <= 1'b1;
        r_mem_we   <= w_victim;
        r_mem_addr <= w_victim ? {w_tag, r_addr[IDX_W-1:0]} : r_addr;
        if (w_victim) r_mem_wdata <= w_line;
      end
      // After a write-back ack the request drops for a cycle before the fill is issued.
      if (r_state == S_FILL && !r_mem_req) begin
        r_mem_req  <= 1'b1;
        r_mem_we   <= 1'b0;
        r_mem_addr <= r_addr;
      end
      if ((r_state == S_WRITEBACK || r_state == S_FILL) && w_ack) r_mem_req <= 1'b0;
      if (r_state == S_FILL && w_ack && r_rw == RD) r_rd_data <= mem_rdata;
    end
  end
  assign rd_data   = r_rd_data;
  assign idle      = r_state == S_IDLE;
  assign done      = r_state == S_DONE;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
`ifdef WBC_STATS_EN
  logic [15:0] r_hit_cnt, r_miss_cnt, r_wb_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_wb_cnt   <= '0;
    end else begin
      if (w_lookup && w_hit && r_hit_cnt != 16'hFFFF) r_hit_cnt <= r_hit_cnt + 16'd1;
      if (w_lookup && !w_hit && r_miss_cnt != 16'hFFFF) r_miss_cnt <= r_miss_cnt + 16'd1;
      if (r_state == S_WRITEBACK && w_ack && r_wb_cnt != 16'hFFFF) r_wb_cnt <= r_wb_cnt + 16'd1;
    end
  end
  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
  assign wb_cnt   = r_wb_cnt;
`endif
endmodule
